i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) responder with an 8-bit register-pointer protocol, the counterpart to the codebase's I2C initiator. It oversamples raw SCL/SDA pad inputs on the system clock, detects START/STOP, matches a 7-bit address, and maps I2C byte writes and reads onto a simple external register-file port with an auto-incrementing pointer. SDA is driven open-drain by the parent: `sda_out` = 1 releases the line, 0 pulls it low. There is no clock stretching.

## Interface
- `ADDR`, 7'h50, 7-bit target address.
- `clk`  in  1  system clock; must be at least 16x SCL frequency.
- `rst`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  raw SCL pad level (asynchronous).
- `sda_in`  in  1  raw SDA pad level (asynchronous).
- `sda_out`  out  1  open-drain SDA control (1 = release).
- `reg_addr`  out  8  register pointer.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-clk write strobe.
- `reg_rdata`  in  8  read data for `reg_addr`; valid one clk after `reg_addr` changes.
- `busy`  out  1  high while an addressed transaction is active.

## Operation
- **Input conditioning:** 2-FF synchronizer on each line gives `scl_s`/`sda_s`, plus a 1-clk delayed copy of each for edge detection.
- **Bus events:**
  - START = `scl_s` high on both samples and SDA 1->0.
  - STOP = `scl_s` high on both samples and SDA 0->1.
  - If SCL and SDA change in the same sample, treat it as an SCL edge only.
  - Bits are sampled on the SCL rising edge.
  - `sda_out` changes only on the SCL falling edge, or on START/STOP/reset.
- **Shifting:** MSB first; 3-bit bit counter; 8-bit shift register.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- **START from any state** (repeated start included): go to ADDR, clear bit counter, release SDA.
- **STOP from any state:** go to IDLE, release SDA, `busy` = 0.
- **ADDR:** on the 8th SCL rise, compare `shift[7:1]` to `ADDR` and latch R/W.
  - Mismatch: go to WAIT with SDA released (NACK); `busy` stays 0.
  - Match: `busy` = 1. On the next SCL fall, drive `sda_out` = 0 and enter ADDR_ACK.
- **ADDR_ACK:** on the SCL fall that ends the ACK bit:
  - Write: release SDA and go to PTR.
  - Read: drive `reg_rdata[7]` and go to RDATA. The transmit shift register is loaded from `reg_rdata` at the ACK-bit SCL rise.
- **PTR:** on the 8th rise, `reg_addr` <= byte. ACK as above, then go to WDATA.
- **WDATA:** on the 8th rise, `reg_wdata` <= byte and `reg_we` = 1 for exactly one clk with the current `reg_addr`. On the next clk, `reg_addr` increments. ACK, then stay in WDATA.
- **RDATA:**
  - Shift out one bit per SCL fall.
  - On the 8th SCL rise, `reg_addr` increments.
  - On the following SCL fall, release SDA and enter RDATA_ACK.
- **RDATA_ACK:** sample SDA at the SCL rise.
  - 0 (ACK): load the shift register from `reg_rdata`, drive bit 7 on the SCL fall, return to RDATA.
  - 1 (NACK): go to WAIT with SDA released.
- **WAIT:** ignore SCL edges until START or STOP.
- **Pointer:** `reg_addr` wraps 8'hFF -> 8'h00 and persists across transactions. A read issued after a pointer write plus repeated start uses that pointer.

## Timing
- **Reset values:** `sda_out` = 1, `reg_we` = 0, `reg_addr` = 0, `reg_wdata` = 0, `busy` = 0, state = IDLE.
- **Reset mid-transaction:** `sda_out` = 1 on the clk after `rst` is sampled high, even while driving ACK or data 0.
- **Latency:**
  - Pad edge to internal detection: 3 clk.
  - `sda_out` update: 1 clk after the detected SCL fall (4 clk after the pad edge).
  - `reg_we` pulse: 1 clk after the detected 8th SCL rise.
- **`reg_rdata` validity:** must be valid 1 clk after any `reg_addr` change. It is captured only at ACK-bit SCL rises, which are at least 8 clk after the increment.
- **STOP or START mid-byte:** partial byte discarded; no `reg_we`; `reg_addr` unchanged.

## Test plan
- **Write burst:** START, 0xA0, 0x10, 0xAB, 0xCD, STOP -> four ACKs (SDA low during each 9th bit); `reg_we` pulses with (0x10, 0xAB) then (0x11, 0xCD); final `reg_addr` = 0x12.
- **Address mismatch:** START, 0xA2, 0x10, STOP -> `sda_out` stays 1 throughout; no `reg_we`; `busy` stays 0.
- **Random read:** START, 0xA0, 0x20, repeated START, 0xA1, read two bytes (master ACK then NACK), STOP. Model `reg_rdata` = `reg_addr` ^ 0x5A -> SDA bytes 0x7A, 0x7B; `reg_addr` ends 0x22; SDA released after NACK.
- **Wrap-around:** write pointer 0xFF, data 0x01, 0x02 -> writes to 0xFF then 0x00.
- **Aborted byte:** STOP after 4 data bits -> IDLE, no `reg_we`, `sda_out` = 1, `busy` = 0.
- **Reset during ACK:** assert `rst` while `sda_out` = 0 -> `sda_out` = 1 next clk, `reg_addr` = 0, and the next full transaction behaves normally.

Source files
------------

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_target
//  Purpose  : I2C target (slave) responder with an 8-bit register pointer.
//             Oversamples raw SCL/SDA on clk, detects START/STOP, matches a
//             7-bit address and maps byte writes/reads onto a simple register
//             file port with an auto-incrementing pointer. No clock stretching.
//  Ports    : clk, rst        - system clock (>= 16x SCL), sync active-high reset
//             scl_in, sda_in  - raw asynchronous pad levels
//             sda_out         - open-drain control (1 = release, 0 = pull low)
//             reg_addr        - register pointer
//             reg_wdata       - write data
//             reg_we          - one-clk write strobe
//             reg_rdata       - read data for reg_addr (valid 1 clk later)
//             busy            - addressed transaction in progress
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT      = 4'd9;

  // Synchronizer chain: meta -> s (synchronized) -> d (one-clk delayed copy)
  logic scl_meta_q, scl_meta_d, scl_s_q, scl_s_d, scl_dly_q, scl_dly_d;
  logic sda_meta_q, sda_meta_d, sda_s_q, sda_s_d, sda_dly_q, sda_dly_d;

  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       done_q, done_d;       // byte (or master ACK) complete, act on next SCL fall
  logic       sda_out_q, sda_out_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  // START/STOP require SCL stable high across both samples, so a sample in
  // which SCL and SDA both move is seen purely as an SCL edge.
  assign scl_rise  =  scl_s_q & ~scl_dly_q;
  assign scl_fall  = ~scl_s_q &  scl_dly_q;
  assign start_det =  scl_s_q &  scl_dly_q &  sda_dly_q & ~sda_s_q;
  assign stop_det  =  scl_s_q &  scl_dly_q & ~sda_dly_q &  sda_s_q;
  assign shift_in  = {shift_q[6:0], sda_s_q};

  always_comb begin
    scl_meta_d = scl_in;
    scl_s_d    = scl_meta_q;
    scl_dly_d  = scl_s_q;
    sda_meta_d = sda_in;
    sda_s_d    = sda_meta_q;
    sda_dly_d  = sda_s_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    done_d      = done_q;
    sda_out_d   = sda_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    busy_d      = busy_q;

    // Pointer advances the clk after the write strobe so the strobe carries
    // the address the byte was written to.
    if (reg_we_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    if (start_det) begin
      state_d   = ST_ADDR;
      cnt_d     = 3'd0;
      done_d    = 1'b0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda_s_q;
              // shift_q[6:0] becomes shift[7:1] of the completed byte
              if (shift_q[6:0] == ADDR) begin
                busy_d = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end else if (scl_fall && done_q) begin
            sda_out_d = 1'b0;
            done_d    = 1'b0;
            state_d   = ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_rise && rw_q) begin
            shift_d = reg_rdata;
          end else if (scl_fall) begin
            cnt_d = 3'd0;
            if (rw_q) begin
              sda_out_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              state_d   = ST_RDATA;
            end else begin
              sda_out_d = 1'b1;
              state_d   = ST_PTR;
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              reg_addr_d = shift_in;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            sda_out_d = 1'b0;
            done_d    = 1'b0;
            state_d   = ST_PTR_ACK;
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              reg_wdata_d = shift_in;
              reg_we_d    = 1'b1;
              done_d      = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            sda_out_d = 1'b0;
            done_d    = 1'b0;
            state_d   = ST_WDATA_ACK;
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            cnt_d     = 3'd0;
            state_d   = ST_WDATA;
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              reg_addr_d = reg_addr_q + 8'd1;
              done_d     = 1'b1;
            end
          end else if (scl_fall) begin
            if (done_q) begin
              sda_out_d = 1'b1;
              done_d    = 1'b0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_out_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s_q) begin
              shift_d = reg_rdata;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (scl_fall && done_q) begin
            sda_out_d = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            done_d    = 1'b0;
            cnt_d     = 3'd0;
            state_d   = ST_RDATA;
          end
        end

        ST_IDLE, ST_WAIT: begin
          // Only START/STOP leave these states.
        end

        default: begin
          state_d   = ST_IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q  <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_dly_q   <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_dly_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      sda_out_q   <= 1'b1;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_meta_q  <= scl_meta_d;
      scl_s_q     <= scl_s_d;
      scl_dly_q   <= scl_dly_d;
      sda_meta_q  <= sda_meta_d;
      sda_s_q     <= sda_s_d;
      sda_dly_q   <= sda_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      sda_out_q   <= sda_out_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_out   = sda_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target
//  Purpose  : Self-checking bench for i2c_target. A bit-banged I2C master
//             pushes the expected sda_out level for every SCL-high phase and
//             every expected register write into queues; independent
//             monitors pop and compare when SCL is high / reg_we is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

  localparam int Q = 10;  // quarter SCL period in clk
  localparam int H = 20;  // half SCL period in clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_out;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int bit_no   = 0;

  logic        sda_q[$];
  logic [15:0] we_q[$];
  logic        sda_exp;
  logic [15:0] we_exp;
  logic        busy_seen;

  assign sda_bus = sda_m & sda_out;

  i2c_target #(.ADDR(7'h50)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_out   (sda_out),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register file model: read data is address XOR 0x5A, one clk behind.
  always @(posedge clk) reg_rdata <= reg_addr ^ 8'h5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // SDA monitor: checks the target's drive in the middle of every SCL-high phase.
  initial begin
    forever begin
      @(posedge scl_m);
      repeat (10) @(negedge clk);
      bit_no++;
      if (sda_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sda_unexpected_bit%0d: got sda_out=%0b with no expectation queued", bit_no, sda_out);
      end else begin
        sda_exp = sda_q.pop_front();
        chk($sformatf("sda_bit%0d", bit_no), {31'd0, sda_out}, {31'd0, sda_exp});
      end
    end
  end

  // Write monitor: every reg_we clk must match the next queued (addr, data).
  always @(negedge clk) begin
    if (reg_we) begin
      if (we_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL we_unexpected: got addr=0x%0h data=0x%0h with no write expected", reg_addr, reg_wdata);
      end else begin
        we_exp = we_q.pop_front();
        chk("we_addr", {24'd0, reg_addr},  {24'd0, we_exp[15:8]});
        chk("we_data", {24'd0, reg_wdata}, {24'd0, we_exp[7:0]});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  // Entry/exit with SCL just fallen (low). e = expected sda_out while SCL high.
  task automatic send_bit(input logic b, input logic e);
    wait_clk(Q);
    sda_m = b;
    wait_clk(Q);
    sda_q.push_back(e);
    scl_m = 1'b1;
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic start_cond(input logic rep);
    if (rep) begin
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
      sda_q.push_back(1'b1);
      scl_m = 1'b1;
    end
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    sda_q.push_back(1'b1);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
    send_bit(1'b1, ~acked);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic mack);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, exp[i]);
    send_bit(~mack, 1'b1);
  endtask

  initial begin
    int n;
    busy_seen = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_clk(5);

    // Reset state
    chk("rst_sda_out",   {31'd0, sda_out},   32'd1);
    chk("rst_reg_we",    {31'd0, reg_we},    32'd0);
    chk("rst_reg_addr",  {24'd0, reg_addr},  32'h00);
    chk("rst_reg_wdata", {24'd0, reg_wdata}, 32'h00);
    chk("rst_busy",      {31'd0, busy},      32'd0);

    // Write burst
    we_q.push_back({8'h10, 8'hAB});
    we_q.push_back({8'h11, 8'hCD});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b1);
    chk("wr_busy_active", {31'd0, busy}, 32'd1);
    send_byte(8'h10, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    stop_cond();
    chk("wr_final_addr", {24'd0, reg_addr}, 32'h12);
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Address mismatch
    busy_seen = 1'b0;
    start_cond(1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'h10, 1'b0);
    stop_cond();
    chk("mis_busy_never", {31'd0, busy_seen}, 32'd0);
    chk("mis_addr_kept",  {24'd0, reg_addr},  32'h12);

    // Random read: pointer 0x20, repeated start, two bytes
    start_cond(1'b0);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h20, 1'b1);
    start_cond(1'b1);
    send_byte(8'hA1, 1'b1);
    recv_byte(8'h7A, 1'b1);
    recv_byte(8'h7B, 1'b0);
    stop_cond();
    chk("rd_final_addr", {24'd0, reg_addr}, 32'h22);
    chk("rd_sda_released", {31'd0, sda_out}, 32'd1);

    // Pointer wrap-around
    we_q.push_back({8'hFF, 8'h01});
    we_q.push_back({8'h00, 8'h02});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    stop_cond();
    chk("wrap_final_addr", {24'd0, reg_addr}, 32'h01);

    // Aborted byte: STOP after 4 data bits
    start_cond(1'b0);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h40, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    stop_cond();
    chk("abort_addr",    {24'd0, reg_addr}, 32'h40);
    chk("abort_busy",    {31'd0, busy},     32'd0);
    chk("abort_sda_out", {31'd0, sda_out},  32'd1);

    // Reset while the target is driving the address ACK
    start_cond(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 8'h00, 1'b1);
    n = 0;
    while (sda_out !== 1'b0 && n < 30) begin
      wait_clk(1);
      n++;
    end
    chk("rstack_driven", {31'd0, sda_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstack_sda_out", {31'd0, sda_out},  32'd1);
    chk("rstack_addr",    {24'd0, reg_addr}, 32'h00);
    chk("rstack_busy",    {31'd0, busy},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    stop_cond();

    we_q.push_back({8'h05, 8'h99});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h99, 1'b1);
    stop_cond();
    chk("post_rst_addr", {24'd0, reg_addr}, 32'h06);

    wait_clk(H);
    chk("sda_queue_drained", sda_q.size(), 32'd0);
    chk("we_queue_drained",  we_q.size(),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
